// File: rtl/pps_div_regbank.sv
// rtl/pps_div_regbank.sv - double-buffered per-channel PPS divider register bank
// Shadow registers are written from the host bus; active registers reload atomically (immediately or on PPS).
module pps_div_regbank #(
  parameter int                  N_CH        = 4,
  parameter int                  DATA_WIDTH  = 8,
  parameter int                  ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 8'h00,
  parameter int                  CH_STRIDE   = 16,
  parameter int                  PHASE_BYTES = 3
) (
  input  logic                                    i_clk_10,
  input  logic                                    i_rst,
  input  logic [ADDR_WIDTH-1:0]                   i_addr,
  input  logic [DATA_WIDTH-1:0]                   i_data,
  input  logic                                    i_wr,
  input  logic                                    i_pps,
  output logic [DATA_WIDTH-1:0]                   o_data,
  output logic [N_CH*DATA_WIDTH-1:0]              o_periodic_true,
  output logic [N_CH*DATA_WIDTH-1:0]              o_div_number,
  output logic [N_CH*PHASE_BYTES*DATA_WIDTH-1:0]  o_phase_us,
  output logic [N_CH*DATA_WIDTH-1:0]              o_width_us,
  output logic [N_CH*DATA_WIDTH-1:0]              o_start,
  output logic [N_CH*DATA_WIDTH-1:0]              o_stop,
  output logic [N_CH-1:0]                         o_update,
  output logic [N_CH-1:0]                         o_pending
);

  localparam int DW    = DATA_WIDTH;
  localparam int NREG  = PHASE_BYTES + 5;
  localparam int OFF_W = $clog2(CH_STRIDE);
  localparam logic [OFF_W-1:0]      OFF_CTRL   = OFF_W'(8);
  localparam logic [OFF_W-1:0]      OFF_STATUS = OFF_W'(9);
  localparam logic [ADDR_WIDTH-1:0] GLOBAL_REL = ADDR_WIDTH'(N_CH * CH_STRIDE);

  typedef enum logic {S_IDLE, S_ARMED} state_t;

  logic [DW-1:0]         shadow [N_CH][NREG];
  logic [DW-1:0]         active [N_CH][NREG];
  state_t                state_q [N_CH];
  state_t                state_d [N_CH];
  logic [N_CH-1:0]       imm_q, loaded_q, update_q, pending;
  logic [N_CH-1:0]       sel, ctrl_wr, cancel, commit, load;
  logic [ADDR_WIDTH:0]   addr_diff;
  logic [ADDR_WIDTH-1:0] rel_addr, ch_num;
  logic [OFF_W-1:0]      off;
  logic                  in_range, glob_hit, glob_wr;
  logic [DW-1:0]         rd_data;

  // Extra bit on the subtraction detects addresses below BASE_ADDR.
  assign addr_diff = {1'b0, i_addr} - {1'b0, BASE_ADDR};
  assign in_range  = !addr_diff[ADDR_WIDTH];
  assign rel_addr  = addr_diff[ADDR_WIDTH-1:0];
  assign ch_num    = rel_addr >> OFF_W;
  assign off       = rel_addr[OFF_W-1:0];
  assign glob_hit  = in_range && (rel_addr == GLOBAL_REL);
  assign glob_wr   = i_wr && glob_hit;

  always_comb begin
    sel     = '0;
    ctrl_wr = '0;
    cancel  = '0;
    commit  = '0;
    load    = '0;
    pending = '0;
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      sel[c]     = in_range && (ch_num == ADDR_WIDTH'(c));
      ctrl_wr[c] = i_wr && sel[c] && (off == OFF_CTRL);
      cancel[c]  = ctrl_wr[c] && i_data[2];
      commit[c]  = !cancel[c] && ((ctrl_wr[c] && i_data[0]) || (glob_wr && i_data[c]));
      pending[c] = (state_q[c] == S_ARMED);
      case (state_q[c])
        S_IDLE: begin
          // A CTRL write's own IMM bit decides how that same commit is applied.
          if (commit[c]) begin
            if (ctrl_wr[c] ? i_data[1] : imm_q[c]) load[c] = 1'b1;
            else                                    state_d[c] = S_ARMED;
          end
        end
        S_ARMED: begin
          if (cancel[c]) begin
            state_d[c] = S_IDLE;
          end else if (i_pps) begin
            load[c]    = 1'b1;
            state_d[c] = S_IDLE;
          end
        end
        default: state_d[c] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_10) begin
    for (int c = 0; c < N_CH; c++) begin
      state_q[c] <= i_rst ? S_IDLE : state_d[c];
    end
  end

  always_ff @(posedge i_clk_10) begin
    if (i_rst) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int r = 0; r < NREG; r++) begin
          shadow[c][r] <= '0;
          active[c][r] <= '0;
        end
      end
      imm_q    <= '0;
      loaded_q <= '0;
      update_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (load[c]) begin
          for (int r = 0; r < NREG; r++) active[c][r] <= shadow[c][r];
          loaded_q[c] <= 1'b1;
        end
        for (int r = 0; r < NREG; r++) begin
          if (i_wr && sel[c] && (off == OFF_W'(r))) shadow[c][r] <= i_data;
        end
        if (ctrl_wr[c]) imm_q[c] <= i_data[1];
      end
      update_q <= load;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel[c]) begin
        for (int r = 0; r < NREG; r++) begin
          if (off == OFF_W'(r)) rd_data = shadow[c][r];
        end
        if (off == OFF_CTRL)   rd_data = DW'({imm_q[c], 1'b0});
        if (off == OFF_STATUS) rd_data = DW'({loaded_q[c], pending[c]});
      end
    end
    if (glob_hit) rd_data = DW'(pending);
  end

  always_ff @(posedge i_clk_10) begin
    if (i_rst)      o_data <= '0;
    else if (!i_wr) o_data <= rd_data;
  end

  assign o_update  = update_q;
  assign o_pending = pending;

  for (genvar c = 0; c < N_CH; c++) begin : g_out
    assign o_periodic_true[c*DW +: DW] = active[c][0];
    assign o_div_number[c*DW +: DW]    = active[c][1];
    for (genvar b = 0; b < PHASE_BYTES; b++) begin : g_phase
      assign o_phase_us[(c*PHASE_BYTES+b)*DW +: DW] = active[c][2+b];
    end
    assign o_width_us[c*DW +: DW] = active[c][PHASE_BYTES+2];
    assign o_start[c*DW +: DW]    = active[c][PHASE_BYTES+3];
    assign o_stop[c*DW +: DW]     = active[c][PHASE_BYTES+4];
  end

endmodule

// File: tb/tb_pps_div_regbank.sv
// tb/tb_pps_div_regbank.sv - self-checking bench for pps_div_regbank
// Directed vector table, hand sequences for commit corner cases, then random traffic against a register-level model.
module tb_pps_div_regbank;

  logic        i_clk_10 = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_addr = '0;
  logic [7:0]  i_data = '0;
  logic        i_wr = 1'b0;
  logic        i_pps = 1'b0;
  logic [7:0]  o_data;
  logic [31:0] o_periodic_true, o_div_number, o_width_us, o_start, o_stop;
  logic [95:0] o_phase_us;
  logic [3:0]  o_update, o_pending;
  logic [255:0] dut_active;

  pps_div_regbank dut (
    .i_clk_10(i_clk_10), .i_rst(i_rst), .i_addr(i_addr), .i_data(i_data),
    .i_wr(i_wr), .i_pps(i_pps), .o_data(o_data),
    .o_periodic_true(o_periodic_true), .o_div_number(o_div_number),
    .o_phase_us(o_phase_us), .o_width_us(o_width_us), .o_start(o_start),
    .o_stop(o_stop), .o_update(o_update), .o_pending(o_pending)
  );

  always #50 i_clk_10 = ~i_clk_10;

  assign dut_active = {o_periodic_true, o_div_number, o_phase_us, o_width_us, o_start, o_stop};

  int n_tests = 0;
  int n_fail  = 0;

  // Register-level model: byte 0 per_true, 1 div, 2..4 phase, 5 width, 6 start, 7 stop.
  logic [7:0] m_sh  [4][8];
  logic [7:0] m_act [4][8];
  logic [3:0] m_imm, m_pend, m_ld, m_upd;
  logic [7:0] m_odata;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       pps;
    logic [7:0] e_data;
    logic [3:0] e_upd;
    logic [3:0] e_pend;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int ch, off;
    ch  = int'(a >> 4);
    off = int'(a & 8'h0f);
    if (a < 8'h40) begin
      if (off < 8)  return m_sh[ch][off];
      if (off == 8) return {6'b0, m_imm[ch], 1'b0};
      if (off == 9) return {6'b0, m_ld[ch], m_pend[ch]};
      return 8'h00;
    end
    if (a == 8'h40) return {4'b0, m_pend};
    return 8'h00;
  endfunction

  function automatic logic [255:0] exp_active();
    logic [31:0] p, dv, w, s, t;
    logic [95:0] ph;
    p = '0; dv = '0; w = '0; s = '0; t = '0; ph = '0;
    for (int c = 0; c < 4; c++) begin
      p[c*8 +: 8]  = m_act[c][0];
      dv[c*8 +: 8] = m_act[c][1];
      for (int b = 0; b < 3; b++) ph[(c*3+b)*8 +: 8] = m_act[c][2+b];
      w[c*8 +: 8]  = m_act[c][5];
      s[c*8 +: 8]  = m_act[c][6];
      t[c*8 +: 8]  = m_act[c][7];
    end
    return {p, dv, ph, w, s, t};
  endfunction

  task automatic model_edge(input logic rst, input logic wr, input logic [7:0] a,
                            input logic [7:0] d, input logic pps);
    logic is_ctrl, cancel, commit, imm, ld;
    int ch, off;
    if (rst) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 8; r++) begin
          m_sh[c][r]  = 8'h00;
          m_act[c][r] = 8'h00;
        end
      m_imm = '0; m_pend = '0; m_ld = '0; m_upd = '0; m_odata = '0;
    end else begin
      if (!wr) m_odata = m_read(a);
      for (int c = 0; c < 4; c++) begin
        is_ctrl = wr && (a == 8'(c*16 + 8));
        cancel  = is_ctrl && d[2];
        commit  = !cancel && ((is_ctrl && d[0]) || (wr && a == 8'h40 && d[c]));
        imm     = is_ctrl ? d[1] : m_imm[c];
        ld      = 1'b0;
        if (m_pend[c]) begin
          if (cancel) m_pend[c] = 1'b0;
          else if (pps) begin
            ld = 1'b1;
            m_pend[c] = 1'b0;
          end
        end else if (commit) begin
          if (imm) ld = 1'b1;
          else     m_pend[c] = 1'b1;
        end
        m_upd[c] = ld;
        if (ld) begin
          for (int r = 0; r < 8; r++) m_act[c][r] = m_sh[c][r];
          m_ld[c] = 1'b1;
        end
      end
      if (wr && a < 8'h40) begin
        ch  = int'(a >> 4);
        off = int'(a & 8'h0f);
        if (off < 8)       m_sh[ch][off] = d;
        else if (off == 8) m_imm[ch] = d[1];
      end
    end
  endtask

  task automatic step(input logic rst, input logic wr, input logic [7:0] a,
                      input logic [7:0] d, input logic pps);
    i_rst = rst; i_wr = wr; i_addr = a; i_data = d; i_pps = pps;
    @(posedge i_clk_10);
    model_edge(rst, wr, a, d, pps);
    @(negedge i_clk_10);
    chk("o_data", o_data, m_odata);
    chk("o_update", o_update, m_upd);
    chk("o_pending", o_pending, m_pend);
    chk("active_set", dut_active, exp_active());
  endtask

  function automatic void add(input logic rst, input logic wr, input logic [7:0] a,
                              input logic [7:0] d, input logic pps, input logic [7:0] ed,
                              input logic [3:0] eu, input logic [3:0] ep);
    vec_t v;
    v.rst = rst; v.wr = wr; v.addr = a; v.data = d; v.pps = pps;
    v.e_data = ed; v.e_upd = eu; v.e_pend = ep;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] a, d;
    logic       wr, rst, pps;
    int         r;

    add(1, 0, 8'h00, 8'h00, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 0, 8'h01, 8'h00, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 0, 8'h04, 8'h00, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 0, 8'h07, 8'h00, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 0, 8'h08, 8'h00, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 0, 8'h09, 8'h00, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 1, 8'h11, 8'h0A, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 1, 8'h12, 8'h40, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 1, 8'h13, 8'h42, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 1, 8'h14, 8'h0F, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 0, 8'h11, 8'h00, 0, 8'h0A, 4'b0000, 4'b0000);
    add(0, 1, 8'h18, 8'h03, 0, 8'h0A, 4'b0010, 4'b0000);
    add(0, 0, 8'h18, 8'h00, 0, 8'h02, 4'b0000, 4'b0000);
    add(0, 0, 8'h19, 8'h00, 0, 8'h02, 4'b0000, 4'b0000);
    add(0, 1, 8'h00, 8'h01, 0, 8'h02, 4'b0000, 4'b0000);
    add(0, 1, 8'h08, 8'h01, 1, 8'h02, 4'b0000, 4'b0001);
    add(0, 0, 8'h40, 8'h00, 0, 8'h01, 4'b0000, 4'b0001);
    add(0, 0, 8'h09, 8'h00, 1, 8'h01, 4'b0001, 4'b0000);
    add(0, 0, 8'h09, 8'h00, 0, 8'h02, 4'b0000, 4'b0000);
    add(0, 0, 8'h50, 8'h00, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 1, 8'h09, 8'hFF, 0, 8'h00, 4'b0000, 4'b0000);
    add(0, 0, 8'h09, 8'h00, 0, 8'h02, 4'b0000, 4'b0000);

    @(negedge i_clk_10);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].pps);
      chk($sformatf("vec%0d_data", i), o_data, vecs[i].e_data);
      chk($sformatf("vec%0d_update", i), o_update, vecs[i].e_upd);
      chk($sformatf("vec%0d_pending", i), o_pending, vecs[i].e_pend);
    end
    chk("ch1_div_number", o_div_number[15:8], 8'h0A);
    chk("ch1_phase", o_phase_us[47:24], 24'h0F4240);
    chk("ch0_periodic", o_periodic_true[7:0], 8'h01);

    // Global commit on channels 0, 2, 3 with shadow edits while armed.
    step(0, 1, 8'h05, 8'h11, 0);
    step(0, 1, 8'h25, 8'h22, 0);
    step(0, 1, 8'h37, 8'h33, 0);
    step(0, 1, 8'h40, 8'h0D, 0);
    chk("glob_pending", o_pending, 4'b1101);
    step(0, 1, 8'h25, 8'h23, 0);
    step(0, 1, 8'h25, 8'h24, 0);
    chk("glob_no_early_load", o_width_us[23:16], 8'h00);
    step(0, 0, 8'h00, 8'h00, 1);
    chk("glob_update", o_update, 4'b1101);
    chk("glob_ch2_width", o_width_us[23:16], 8'h24);
    chk("glob_ch0_width", o_width_us[7:0], 8'h11);
    chk("glob_ch3_stop", o_stop[31:24], 8'h33);
    chk("glob_pending_clr", o_pending, 4'b0000);
    step(0, 0, 8'h00, 8'h00, 0);
    chk("glob_update_1cyc", o_update, 4'b0000);

    // Cancel beats commit in the same CTRL write.
    step(0, 1, 8'h38, 8'h01, 0);
    chk("cancel_armed", o_pending, 4'b1000);
    step(0, 1, 8'h36, 8'h77, 0);
    step(0, 1, 8'h38, 8'h05, 0);
    chk("cancel_pending", o_pending, 4'b0000);
    step(0, 0, 8'h00, 8'h00, 1);
    chk("cancel_no_update", o_update, 4'b0000);
    chk("cancel_start_kept", o_start[31:24], 8'h00);

    // Repeated commit gives one load; same-cycle shadow write misses the load.
    step(0, 1, 8'h28, 8'h01, 0);
    step(0, 1, 8'h40, 8'h04, 0);
    chk("rep_pending", o_pending, 4'b0100);
    step(0, 1, 8'h22, 8'h99, 1);
    chk("rep_update", o_update, 4'b0100);
    chk("rep_old_phase", o_phase_us[55:48], 8'h00);
    step(0, 0, 8'h22, 8'h00, 1);
    chk("rep_single_load", o_update, 4'b0000);
    chk("rep_shadow_written", o_data, 8'h99);

    // Reset while armed drops the commit.
    step(0, 1, 8'h08, 8'h01, 0);
    chk("rst_armed", o_pending, 4'b0001);
    step(1, 0, 8'h00, 8'h00, 0);
    step(0, 0, 8'h00, 8'h00, 1);
    chk("rst_no_update", o_update, 4'b0000);
    chk("rst_active_zero", dut_active, 256'h0);
    chk("rst_pending_zero", o_pending, 4'b0000);

    for (int n = 0; n < 700; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      wr  = $urandom_range(0, 1) == 1;
      r   = $urandom_range(0, 7);
      if (r < 6)       a = {2'b00, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 11))};
      else if (r == 6) a = 8'h40;
      else             a = 8'($urandom_range(0, 255));
      if (a[3:0] == 4'h8 && a < 8'h40) d = 8'($urandom_range(0, 7));
      else                             d = 8'($urandom_range(0, 255));
      pps = ($urandom_range(0, 5) == 0);
      step(rst, wr, a, d, pps);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
